// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: 2-flop synchronized input, mid-bit sampling,
// byte strobe, framing-error pulse, trigger-character detect and byte counter.
module uart_cmd_rx #(
  parameter int         SCW       = 16,
  parameter int         sym_cnt   = 40000,
  parameter logic [7:0] TRIG_CHAR = 8'h54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fpga_rx,
  output logic [7:0]  rx_dat,
  output logic        rx_stb,
  output logic        frm_err,
  output logic        trig,
  output logic [15:0] rx_counter
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [SCW-1:0] FULL_CNT = SCW'(sym_cnt - 1);
  localparam logic [SCW-1:0] HALF_CNT = SCW'(sym_cnt / 2 - 1);
  localparam logic [SCW-1:0] CNT_ONE  = SCW'(1);

  state_t          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [SCW-1:0]  cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      dat_q, dat_d;
  logic            stb_q, stb_d;
  logic            ferr_q, ferr_d;
  logic            trig_q, trig_d;
  logic [15:0]     rxc_q, rxc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      ferr_q    <= 1'b0;
      trig_q    <= 1'b0;
      rxc_q     <= '0;
    end else begin
      rx_meta_q <= fpga_rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      ferr_q    <= ferr_d;
      trig_q    <= trig_d;
      rxc_q     <= rxc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dat_d   = dat_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    trig_d  = 1'b0;
    rxc_d   = rxc_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that is gone by mid-bit was a glitch.
          state_d = rxs_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (rxs_q) begin
            dat_d   = shreg_q;
            stb_d   = 1'b1;
            trig_d  = (shreg_q == TRIG_CHAR);
            rxc_d   = rxc_q + 16'd1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_dat     = dat_q;
  assign rx_stb     = stb_q;
  assign frm_err    = ferr_q;
  assign trig       = trig_q;
  assign rx_counter = rxc_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx with 16 clocks per bit.
module tb_uart_cmd_rx;

  localparam int SYM = 16;
  localparam logic [7:0] TCH = 8'h54;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fpga_rx = 1'b1;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic        frm_err;
  logic        trig;
  logic [15:0] rx_counter;

  uart_cmd_rx #(.SCW(16), .sym_cnt(SYM), .TRIG_CHAR(TCH)) dut (
    .clk(clk), .rst(rst), .fpga_rx(fpga_rx),
    .rx_dat(rx_dat), .rx_stb(rx_stb), .frm_err(frm_err),
    .trig(trig), .rx_counter(rx_counter)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  dat;
    logic        trg;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ferr_seen = 0;
  int          exp_ferr = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        prev_stb = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pops one expectation per strobe and checks pulse exclusivity.
  always @(negedge clk) begin
    exp_t e;
    prev_stb <= rx_stb;
    if (rx_stb) begin
      chk("stb_width", 32'(prev_stb), 32'd0);
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rx_dat", 32'(rx_dat), 32'(e.dat));
        chk("trig", 32'(trig), 32'(e.trg));
        chk("rx_counter", 32'(rx_counter), 32'(e.cnt));
        $display("rx byte %02h trig %0b count %04h", rx_dat, trig, rx_counter);
      end
    end
    if (frm_err) begin
      ferr_seen <= ferr_seen + 1;
      chk("ferr_excl", 32'(rx_stb), 32'd0);
      $display("framing error pulse");
    end
    if (trig) chk("trig_with_stb", 32'(rx_stb), 32'd1);
  end

  task automatic drive_bits(input logic [7:0] b, input logic stop_bit);
    fpga_rx = 1'b0;
    repeat (SYM) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      fpga_rx = b[i];
      repeat (SYM) @(negedge clk);
    end
    fpga_rx = stop_bit;
    repeat (SYM) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.dat = b;
    e.trg = (b == TCH);
    e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * SYM && sb_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send_good(input logic [7:0] b);
    push_exp(b);
    drive_bits(b, 1'b1);
    fpga_rx = 1'b1;
    repeat (4) @(negedge clk);
    drain("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_dat", 32'(rx_dat), 32'd0);
    chk("rst_cnt", 32'(rx_counter), 32'd0);
    chk("rst_stb", 32'(rx_stb), 32'd0);
    chk("rst_ferr", 32'(frm_err), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_good(8'h54);
    send_good(8'hA5);

    // Stop bit low, line held low for 40 clocks, then a normal byte.
    exp_ferr++;
    drive_bits(8'h3C, 1'b0);
    repeat (40 - SYM) @(negedge clk);
    chk("ferr_cnt", 32'(ferr_seen), 32'(exp_ferr));
    fpga_rx = 1'b1;
    repeat (4) @(negedge clk);
    send_good(8'h01);

    // Short low glitch on an idle line.
    fpga_rx = 1'b0;
    repeat (4) @(negedge clk);
    fpga_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_ferr", 32'(ferr_seen), 32'(exp_ferr));
    send_good(8'h33);

    // Counter wrap.
    force dut.rxc_q = 16'hFFFF;
    @(negedge clk);
    release dut.rxc_q;
    @(negedge clk);
    exp_cnt = 16'hFFFF;
    send_good(8'h77);
    chk("wrap_cnt", 32'(rx_counter), 32'd0);

    // Reset during bit 4 of 8'hFF.
    fpga_rx = 1'b0;
    repeat (SYM) @(negedge clk);
    fpga_rx = 1'b1;
    repeat (4 * SYM + SYM / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_dat", 32'(rx_dat), 32'd0);
    chk("mid_rst_cnt", 32'(rx_counter), 32'd0);
    rst = 1'b0;
    exp_cnt = 16'd0;
    repeat (6 * SYM) @(negedge clk);
    send_good(8'h54);

    // Reset released while the line is already low: treated as start bit.
    exp_cnt = 16'd0;
    push_exp(8'h5A);
    fpga_rx = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_bits(8'h5A, 1'b1);
    fpga_rx = 1'b1;
    repeat (4) @(negedge clk);
    drain("drain_lowrst");

    chk("final_ferr", 32'(ferr_seen), 32'(exp_ferr));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
